sched_sequencer: RTL
====================

# sched_sequencer

Parametrised schedule sequencer driving per-buffer write/read toggles for a dataflow graph of `NUM_CH` buffers. It stores up to `MAX_PERIOD` control words loaded serially and replays them cyclically, one word per clock, over a runtime-programmable iteration period. It supports continuous or one-shot mode, graceful stop at an iteration boundary, and error flagging. It sits beside the buffer controllers in the dataflow top level, and its toggle outputs wire directly to each buffer's `wr_toggle`/`rd_toggle`.

## Interface
- `NUM_CH`, 12: number of buffer channels.
- `CTRL_WIDTH`, `NUM_CH*2`: control word width. Bit `2i` is the write strobe for channel i; bit `2i+1` is the read strobe for channel i.
- `MAX_PERIOD`, 64: control memory depth in words; must be ≥2.
- `PW`, `$clog2(MAX_PERIOD+1)`: width of period and count fields.
- `ITER_W`, 16: iteration counter width.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_ctrl` in 1: write `ctrl_in` into the next memory slot.
- `clr_ctrl` in 1: reset the load pointer; honoured in IDLE only.
- `ctrl_in` in `CTRL_WIDTH`: control word to load.
- `period_in` in `PW`: iteration length in words; sampled on an accepted start.
- `one_shot` in 1: sampled on an accepted start. 1 = run one iteration; 0 = continuous.
- `start_ctrl` in 1: start request.
- `stop_ctrl` in 1: stop request.
- `buff_wr_toggle` out `NUM_CH`: per-channel write toggle level.
- `buff_rd_toggle` out `NUM_CH`: per-channel read toggle level.
- `busy` out 1: high in RUN or STOPPING.
- `loaded_cnt` out `PW`: number of words loaded.
- `iter_done` out 1: one-cycle pulse when an iteration completes.
- `iter_cnt` out `ITER_W`: completed iterations since the last accepted start.
- `err` out 1: sticky error flag.

## Operation
- States: IDLE, RUN, STOPPING.
- IDLE:
  - `load_ctrl` writes `mem[loaded_cnt]` and increments `loaded_cnt`.
  - A load at `loaded_cnt==MAX_PERIOD` is dropped and sets `err`.
  - `clr_ctrl` sets `loaded_cnt` to 0. Memory contents are kept.
  - `clr_ctrl` and `load_ctrl` together: clear wins, and the word is written to slot 0 with `loaded_cnt` set to 1.
- Start acceptance in IDLE requires `start_ctrl=1`, `stop_ctrl=0`, and `1 ≤ period_in ≤ loaded_cnt`.
  - The `loaded_cnt` used for the check is the value before any same-cycle load.
  - On accept: latch `period_in` and `one_shot`, set `rd_ptr=0`, clear `iter_cnt`, go to RUN.
  - Failing the period check: start rejected, `err` set.
  - `start_ctrl` and `stop_ctrl` together in IDLE: start ignored, no error.
- RUN: each cycle read `mem[rd_ptr]`.
  - For each set bit, invert the corresponding toggle output (registered XOR).
  - `rd_ptr` wraps from period−1 to 0.
  - At wrap: pulse `iter_done` and increment `iter_cnt`, saturating at all-ones.
- `stop_ctrl` in RUN moves to STOPPING. The current iteration completes, then the block returns to IDLE at wrap.
- `one_shot=1`: return to IDLE at the first wrap without needing stop.
- `start_ctrl` outside IDLE is ignored with no error.
- `load_ctrl` or `clr_ctrl` outside IDLE: ignored, and `err` set.
- Toggle levels hold their values in IDLE and are not cleared by start.
- `err` is cleared only by `rst`.

## Timing
- Reset values:
  - state IDLE.
  - `buff_wr_toggle` and `buff_rd_toggle` all 0.
  - `busy` 0, `loaded_cnt` 0, `iter_done` 0, `iter_cnt` 0, `err` 0.
  - `rd_ptr` 0.
  - Memory contents are not reset.
- Reset mid-RUN: IDLE on the next cycle, with all outputs at their reset values.
- Start accepted at cycle N: `busy` is high from N+1. Word k is read at N+1+k, and its toggle effect is visible from N+2+k.
- `iter_done` is high in the cycle in which the last word's toggle effect becomes visible, i.e. N+1+period for the first iteration. `iter_cnt` updates in the same cycle.
- Return to IDLE (stop or one-shot): `busy` falls in the cycle after the final word is read, i.e. the same cycle as the final `iter_done`.
- A load at cycle N is visible in `loaded_cnt` at N+1.
- Period 1: the same word is applied every cycle, and `iter_done` pulses every cycle.

## Configuration
- `SCHED_SEQ_ITER_CNT_EN` defined: `iter_cnt` is implemented as specified.
- `SCHED_SEQ_ITER_CNT_EN` undefined: `iter_cnt` is tied to 0 and no counter is synthesised. `iter_done` is unaffected.

## Test plan
- Load 3 words (0x000001, 0x000002, 0x000003), start with period 3 continuous → `buff_wr_toggle[0]` flips at N+2, N+4, N+5. `buff_rd_toggle[0]` flips at N+3, N+4. `iter_done` at N+4, N+7, and so on.
- One-shot with period 2 after 2 loads → exactly one `iter_done`, `busy` low at N+3, `iter_cnt`=1.
- `stop_ctrl` during word 1 of a period-4 run → words 2 and 3 still applied, then IDLE. `iter_done` fires once more.
- Start with `period_in`=0, and again with `period_in`=5 while `loaded_cnt`=4 → rejected, `err`=1, `busy` stays 0.
- 65 loads with `MAX_PERIOD`=64 → `loaded_cnt`=64, `err`=1. Then `clr_ctrl` → `loaded_cnt`=0, `err` still 1.
- Assert `rst` mid-RUN with toggles nonzero → all outputs 0 at the next cycle. A start with the previous `loaded_cnt` is rejected because `loaded_cnt`=0.

Source files
------------

// File: rtl/sched_sequencer.sv
// sched_sequencer
//   Replays a serially loaded table of control words, one word per clock, over a
//   runtime-programmable period. Each word's set bits flip the matching per-channel
//   write/read toggle levels (bit 2i -> write toggle i, bit 2i+1 -> read toggle i).
//   Supports continuous or one-shot runs, graceful stop at the iteration boundary,
//   and a sticky error flag.
//
//   Optional feature macro: SCHED_SEQ_ITER_CNT_EN
//     defined   -> iter_cnt counts completed iterations since the last accepted start
//     undefined -> iter_cnt is tied to 0 and no counter is built
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   load_ctrl, ctrl_in     : append ctrl_in to the control table (IDLE only)
//   clr_ctrl               : rewind the load pointer (IDLE only)
//   period_in, one_shot    : run configuration, sampled on an accepted start
//   start_ctrl, stop_ctrl  : run control
//   buff_wr_toggle/rd      : per-channel toggle levels
//   busy                   : running or stopping
//   loaded_cnt             : words currently loaded
//   iter_done, iter_cnt    : iteration-complete pulse and count
//   err                    : sticky error
module sched_sequencer #(
  parameter int NUM_CH     = 12,
  parameter int CTRL_WIDTH = NUM_CH*2,
  parameter int MAX_PERIOD = 64,
  parameter int PW         = $clog2(MAX_PERIOD+1),
  parameter int ITER_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_ctrl,
  input  logic                  clr_ctrl,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  input  logic [PW-1:0]         period_in,
  input  logic                  one_shot,
  input  logic                  start_ctrl,
  input  logic                  stop_ctrl,
  output logic [NUM_CH-1:0]     buff_wr_toggle,
  output logic [NUM_CH-1:0]     buff_rd_toggle,
  output logic                  busy,
  output logic [PW-1:0]         loaded_cnt,
  output logic                  iter_done,
  output logic [ITER_W-1:0]     iter_cnt,
  output logic                  err
);

  localparam int AW = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

  state_t                state;
  logic [CTRL_WIDTH-1:0] mem [MAX_PERIOD];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         period_q;
  logic                  one_shot_q;
  logic [CTRL_WIDTH-1:0] rd_word;
  logic [NUM_CH-1:0]     wr_bits, rd_bits;
  logic                  idle, wrap, mem_we, start_req, period_ok;
  logic [AW-1:0]         wr_addr;

  assign idle    = (state == S_IDLE);
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign wrap    = !idle && (rd_ptr == period_q - PW'(1));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_split
    assign wr_bits[i] = rd_word[2*i];
    assign rd_bits[i] = rd_word[2*i+1];
  end

  // A clear in the same cycle as a load redirects the word to slot 0; a load
  // into a full table is dropped.
  assign mem_we    = idle && load_ctrl && (clr_ctrl || loaded_cnt != PW'(MAX_PERIOD));
  assign wr_addr   = clr_ctrl ? '0 : loaded_cnt[AW-1:0];
  // Start with stop in the same cycle is silently ignored.
  assign start_req = idle && start_ctrl && !stop_ctrl;
  // Checked against the count before any same-cycle load.
  assign period_ok = (period_in != '0) && (period_in <= loaded_cnt);

  // Control table is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= ctrl_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rd_ptr         <= '0;
      period_q       <= '0;
      one_shot_q     <= 1'b0;
      loaded_cnt     <= '0;
      buff_wr_toggle <= '0;
      buff_rd_toggle <= '0;
      busy           <= 1'b0;
      iter_done      <= 1'b0;
      err            <= 1'b0;
    end else begin
      iter_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clr_ctrl)
            loaded_cnt <= load_ctrl ? PW'(1) : '0;
          else if (load_ctrl) begin
            if (loaded_cnt == PW'(MAX_PERIOD)) err <= 1'b1;
            else                               loaded_cnt <= loaded_cnt + PW'(1);
          end
          if (start_req) begin
            if (period_ok) begin
              period_q   <= period_in;
              one_shot_q <= one_shot;
              rd_ptr     <= '0;
              state      <= S_RUN;
              busy       <= 1'b1;
            end else
              err <= 1'b1;
          end
        end
        default: begin // S_RUN, S_STOPPING
          if (load_ctrl || clr_ctrl) err <= 1'b1;
          buff_wr_toggle <= buff_wr_toggle ^ wr_bits;
          buff_rd_toggle <= buff_rd_toggle ^ rd_bits;
          if (wrap) begin
            rd_ptr    <= '0;
            iter_done <= 1'b1;
            // A stop arriving on the last word ends the run at this boundary.
            if (one_shot_q || stop_ctrl || state == S_STOPPING) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            rd_ptr <= rd_ptr + PW'(1);
            if (stop_ctrl) state <= S_STOPPING;
          end
        end
      endcase
    end
  end

`ifdef SCHED_SEQ_ITER_CNT_EN
  logic [ITER_W-1:0] iter_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                          iter_cnt_q <= '0;
    else if (start_req && period_ok)  iter_cnt_q <= '0;
    else if (wrap && iter_cnt_q != '1) iter_cnt_q <= iter_cnt_q + ITER_W'(1);
  end
  assign iter_cnt = iter_cnt_q;
`else
  assign iter_cnt = '0;
`endif

endmodule
